// File: rtl/ase_pkg.sv
// Shared constants for the ASE FIFO read-side blocks.
package ase_pkg;

  // Width of the drain adapter statistics counters.
  localparam int DRAIN_STAT_W = 32;

endpackage

// File: rtl/ase_drain_buf.sv
// ase_drain_buf: register-file output buffer for the ASE FIFO drain adapter.
// Each cycle it can take one push and one pop. The head word is read
// combinationally from the registers. Only the control state (pointers and
// occupancy) is reset; the storage is not.
module ase_drain_buf
  import ase_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_W:0]       occ
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;

  // Storage write: a pushed word lands at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at depth; occupancy tracks push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ase_fifo_drain.sv
// ase_fifo_drain: converts the ASE FIFO registered-read port into a
// valid/ready stream. Reads are issued ahead of demand against a credit of
// (buffer occupancy + read in flight), so a word is never lost under
// backpressure.
// Optional statistics counters are built when ASE_FIFO_DRAIN_STATS_EN is defined.
module ase_fifo_drain
  import ase_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BUF_DEPTH_BASE2 = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    fifo_data_v,
  input  logic                    fifo_empty,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic [BUF_DEPTH_BASE2:0] buf_count,
  output logic [DRAIN_STAT_W-1:0] stall_cnt,
  output logic [DRAIN_STAT_W-1:0] orphan_cnt
);

  localparam logic [BUF_DEPTH_BASE2+1:0] DEPTH_C =
    (BUF_DEPTH_BASE2+2)'(1 << BUF_DEPTH_BASE2);

  logic                         inflight;
  logic                         push;
  logic                         pop;
  logic [BUF_DEPTH_BASE2:0]     occ;
  logic [BUF_DEPTH_BASE2+1:0]   credit_used;

  // Credit uses registered state only, so out_ready never reaches fifo_rd_en.
  assign credit_used = {1'b0, occ} + {{(BUF_DEPTH_BASE2+1){1'b0}}, inflight};
  assign fifo_rd_en  = ~fifo_empty & (credit_used < DEPTH_C);

  // Data is accepted only when it answers a read issued last cycle.
  assign push      = fifo_data_v & inflight;
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  assign buf_count = occ;

  // Read-in-flight tracker: mirrors the FIFO's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  ase_drain_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (BUF_DEPTH_BASE2)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (out_data),
    .occ       (occ)
  );

`ifdef ASE_FIFO_DRAIN_STATS_EN
  logic orphan;
  assign orphan = fifo_data_v & ~inflight;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [DRAIN_STAT_W-1:0] sat_inc(input logic [DRAIN_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Statistics: backpressure cycles and unsolicited FIFO data pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      orphan_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (orphan) begin
        orphan_cnt <= sat_inc(orphan_cnt);
      end
    end
  end
`else
  assign stall_cnt  = '0;
  assign orphan_cnt = '0;
`endif

endmodule

// File: tb/tb_ase_fifo_drain.sv
// Testbench for ase_fifo_drain: a behavioural registered-read FIFO feeds the
// adapter and directed scenarios check the stream against hand-derived values.
module tb_ase_fifo_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_rd_en;
  logic [63:0] fifo_data = '0;
  logic        fifo_data_v = 1'b0;
  logic        fifo_empty;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready = 1'b0;
  logic [2:0]  buf_count;
  logic [31:0] stall_cnt;
  logic [31:0] orphan_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO model state: words queued, counters for writes and reads.
  logic [63:0] fq[$];
  int          wr_total = 0;
  int          rd_total = 0;
  logic        inj_v = 1'b0;

  assign fifo_empty = (wr_total == rd_total);

  always #5 clk = ~clk;

  ase_fifo_drain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .fifo_data_v (fifo_data_v),
    .fifo_empty  (fifo_empty),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .buf_count   (buf_count),
    .stall_cnt   (stall_cnt),
    .orphan_cnt  (orphan_cnt)
  );

  // Registered-read FIFO: data and its valid appear one cycle after rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_data   <= fq.pop_front();
      fifo_data_v <= 1'b1;
      rd_total    <= rd_total + 1;
    end else begin
      fifo_data   <= 64'hDEAD_BEEF_0BAD_F00D;
      fifo_data_v <= inj_v;
    end
  end

  task automatic fifo_write(input logic [63:0] d);
    fq.push_back(d);
    wr_total = wr_total + 1;
  endtask

  task automatic fifo_clear();
    fq.delete();
    wr_total = rd_total;
  endtask

  // Leaves the bench at a negedge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b0;
    inj_v = 1'b0;
    fifo_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (buf_count !== 3'd0) begin n_bad++; $display("FAIL reset_buf_count: got %0d want 0", buf_count); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (orphan_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_orphan_cnt: got %0d want 0", orphan_cnt); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en_empty: got %0b want 0", fifo_rd_en); end
    // During reset the read request simply follows ~fifo_empty.
    fifo_write(64'h55);
    #1;
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL reset_rd_en_nonempty: got %0b want 1", fifo_rd_en); end
    fifo_clear();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_drain_burst();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_write(64'(i));
    #1;
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL burst_first_rd_en: got %0b want 1", fifo_rd_en); end
    // rd_en at cycle 0 -> word 1 visible at cycle 2, then one word per cycle.
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      if (k == 1 || k == 10) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL burst_idle_c%0d: got valid %0b want 0", k, out_valid); end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 64'(k - 1)) begin
          n_bad++; $display("FAIL burst_word_c%0d: got valid %0b data %0h want valid 1 data %0h", k, out_valid, out_data, k - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int rd_cnt;
    int unstable;
    logic [63:0] exp;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fifo_write(64'(i));
    rd_cnt = 0;
    unstable = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (fifo_rd_en) rd_cnt++;
      if (out_valid && out_data !== 64'h1) unstable++;
    end
    n_cmp++; if (rd_cnt != 4) begin n_bad++; $display("FAIL bp_read_count: got %0d want 4", rd_cnt); end
    n_cmp++; if (buf_count !== 3'd4) begin n_bad++; $display("FAIL bp_buf_count: got %0d want 4", buf_count); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h1) begin n_bad++; $display("FAIL bp_head: got valid %0b data %0h want valid 1 data 1", out_valid, out_data); end
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_head_stable: got %0d changes want 0", unstable); end
    out_ready = 1'b1;
    exp = 64'h1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (out_valid) begin
        n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL bp_drain_order: got %0h want %0h", out_data, exp); end
        exp++;
      end
    end
    n_cmp++; if (exp !== 64'd9) begin n_bad++; $display("FAIL bp_drain_total: got %0d words want 8", exp - 1); end
  endtask

  task automatic test_alternating_ready();
    logic [63:0] exp;
    int maxc;
    logic [31:0] exp_stall;
    do_reset();
    for (int i = 1; i <= 20; i++) fifo_write(64'(i));
    exp = 64'h1;
    maxc = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      out_ready = (c % 2 == 0);
      if (int'(buf_count) > maxc) maxc = int'(buf_count);
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL alt_order: got %0h want %0h", out_data, exp); end
        exp++;
        if (exp == 64'd21) break;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_cmp++; if (exp !== 64'd21) begin n_bad++; $display("FAIL alt_total: got %0d words want 20", exp - 1); end
    n_cmp++; if (maxc > 4) begin n_bad++; $display("FAIL alt_max_count: got %0d want <=4", maxc); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL alt_drained: got valid %0b want 0", out_valid); end
    // Valid from cycle 2 to 40; ready on even cycles pops, odd cycles 3..39 stall.
`ifdef ASE_FIFO_DRAIN_STATS_EN
    exp_stall = 32'd19;
`else
    exp_stall = 32'd0;
`endif
    n_cmp++; if (stall_cnt !== exp_stall) begin n_bad++; $display("FAIL alt_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_empty_underflow();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL empty_idle_c%0d: got rd_en %0b valid %0b want 0 0", k, fifo_rd_en, out_valid); end
    end
    fifo_write(64'hABCD);
    #1;
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL single_rd_en: got %0b want 1", fifo_rd_en); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL single_c1: got valid %0b rd_en %0b want 0 0", out_valid, fifo_rd_en); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hABCD) begin n_bad++; $display("FAIL single_c2: got valid %0b data %0h want 1 abcd", out_valid, out_data); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_after_c%0d: got valid %0b want 0", k, out_valid); end
    end
  endtask

  task automatic test_wrap_random();
    logic [63:0] sb[$];
    logic [63:0] d;
    logic [63:0] want;
    int total_w;
    int got;
    int over;
    do_reset();
    total_w = 0;
    got = 0;
    over = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      #1;
      if (total_w < 1000 && $urandom_range(0, 3) != 0 && (wr_total - rd_total) < 16) begin
        d = {$urandom, $urandom};
        fifo_write(d);
        sb.push_back(d);
        total_w++;
      end
      out_ready = $urandom_range(0, 1) == 1;
      if (buf_count > 3'd4) over++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL wrap_extra_word: got %0h want none", out_data);
        end else begin
          want = sb.pop_front();
          n_cmp++; if (out_data !== want) begin n_bad++; $display("FAIL wrap_data_%0d: got %0h want %0h", got, out_data, want); end
        end
        got++;
        if (got == 1000) break;
      end
    end
    n_cmp++; if (got != 1000) begin n_bad++; $display("FAIL wrap_total: got %0d want 1000", got); end
    n_cmp++; if (over != 0) begin n_bad++; $display("FAIL wrap_overfill: got %0d cycles over 4 want 0", over); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_cmp++; if (buf_count !== 3'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_final_empty: got count %0d valid %0b want 0 0", buf_count, out_valid); end
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] exp_orphan;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fifo_write(64'(i));
    repeat (4) @(negedge clk);
    #1;
    // Cycle 4: three words buffered, the fourth on the wire with its read in flight.
    n_cmp++; if (buf_count !== 3'd3 || fifo_data_v !== 1'b1) begin n_bad++; $display("FAIL mid_pre_state: got count %0d data_v %0b want 3 1", buf_count, fifo_data_v); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || buf_count !== 3'd0) begin n_bad++; $display("FAIL mid_async_clear: got valid %0b count %0d want 0 0", out_valid, buf_count); end
    fifo_clear();
    @(negedge clk);
    rst_n = 1'b1;
    inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    @(negedge clk);
    #1;
`ifdef ASE_FIFO_DRAIN_STATS_EN
    exp_orphan = 32'd1;
`else
    exp_orphan = 32'd0;
`endif
    n_cmp++; if (orphan_cnt !== exp_orphan) begin n_bad++; $display("FAIL mid_orphan_cnt: got %0d want %0d", orphan_cnt, exp_orphan); end
    n_cmp++; if (out_valid !== 1'b0 || buf_count !== 3'd0) begin n_bad++; $display("FAIL mid_orphan_dropped: got valid %0b count %0d want 0 0", out_valid, buf_count); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_stall_cleared: got %0d want 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_drain_burst();
    test_backpressure();
    test_alternating_ready();
    test_empty_underflow();
    test_wrap_random();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
